vga_tile_renderer: RTL and testbench

//  Pixel-generation stage fed by the VGA timing generator. It converts h_count/v_count into tile-map and

---
 rtl/vga_tile_renderer.sv | 122 ++++++++++++
 tb/tb_vga_tile_renderer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_renderer.sv
// Tile-based pixel pipeline: counts -> tile map -> pattern RAM -> palette -> VGA pins.
// Sync and blank ride alongside the colour path so all pins change on the same edge.
module vga_tile_renderer #(
  parameter int COUNTER_BITS  = 16,
  parameter int MAP_COLS      = 40,
  parameter int MAP_ADDR_BITS = 11,
  parameter int TILE_IDX_BITS = 8
) (
  input  logic                       clk_50MHz,
  input  logic                       clear,
  input  logic                       pix_en,
  input  logic [COUNTER_BITS-1:0]    h_count,
  input  logic [COUNTER_BITS-1:0]    v_count,
  input  logic                       bright,
  input  logic                       h_sync,
  input  logic                       v_sync,
  output logic [MAP_ADDR_BITS-1:0]   tile_addr,
  input  logic [TILE_IDX_BITS-1:0]   tile_data,
  output logic [TILE_IDX_BITS+7:0]   pat_addr,
  input  logic [3:0]                 pat_data,
  input  logic                       pal_we,
  input  logic [3:0]                 pal_idx,
  input  logic [7:0]                 pal_data,
  output logic [7:0]                 rgb,
  output logic                       vga_hsync,
  output logic                       vga_vsync,
  output logic                       vga_blank_n
);

  localparam logic [MAP_ADDR_BITS-1:0] COLS_C = MAP_ADDR_BITS'(MAP_COLS);

  logic [MAP_ADDR_BITS-1:0] v_tile, h_tile, tile_addr_d, tile_addr_q;
  logic [MAP_ADDR_BITS-1:0] part [MAP_ADDR_BITS];

  logic [3:0]               col_q, row_q;
  logic                     s1_bright_q, s1_hs_q, s1_vs_q;
  logic [TILE_IDX_BITS+7:0] pat_addr_q;
  logic                     s2_bright_q, s2_hs_q, s2_vs_q;
  logic [3:0]               pix_idx_q;
  logic                     s3_bright_q, s3_hs_q, s3_vs_q;
  logic [7:0]               rgb_q;
  logic                     hsync_q, vsync_q, blank_n_q;
  logic [7:0]               pal_q [16];

  assign v_tile = MAP_ADDR_BITS'(v_count >> 4);
  assign h_tile = MAP_ADDR_BITS'(h_count >> 4);

  // Row-stride multiply as a sum of shifted copies, one per set bit of MAP_COLS.
  genvar gi;
  generate
    for (gi = 0; gi < MAP_ADDR_BITS; gi++) begin : g_pp
      assign part[gi] = COLS_C[gi] ? (v_tile << gi) : '0;
    end
  endgenerate

  always_comb begin
    tile_addr_d = h_tile;
    for (int k = 0; k < MAP_ADDR_BITS; k++) begin
      tile_addr_d = tile_addr_d + part[k];
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (clear) begin
      col_q       <= '0;
      row_q       <= '0;
      s1_bright_q <= 1'b0;
      s1_hs_q     <= 1'b1;
      s1_vs_q     <= 1'b1;
      tile_addr_q <= '0;
      pat_addr_q  <= '0;
      s2_bright_q <= 1'b0;
      s2_hs_q     <= 1'b1;
      s2_vs_q     <= 1'b1;
      pix_idx_q   <= '0;
      s3_bright_q <= 1'b0;
      s3_hs_q     <= 1'b1;
      s3_vs_q     <= 1'b1;
      rgb_q       <= 8'h00;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      blank_n_q   <= 1'b0;
    end else if (pix_en) begin
      col_q       <= h_count[3:0];
      row_q       <= v_count[3:0];
      s1_bright_q <= bright;
      s1_hs_q     <= h_sync;
      s1_vs_q     <= v_sync;
      // Address holds during blanking so off-screen counts never reach the RAMs.
      if (bright) tile_addr_q <= tile_addr_d;
      pat_addr_q  <= {tile_data, row_q, col_q};
      s2_bright_q <= s1_bright_q;
      s2_hs_q     <= s1_hs_q;
      s2_vs_q     <= s1_vs_q;
      pix_idx_q   <= pat_data;
      s3_bright_q <= s2_bright_q;
      s3_hs_q     <= s2_hs_q;
      s3_vs_q     <= s2_vs_q;
      rgb_q       <= s3_bright_q ? pal_q[pix_idx_q] : 8'h00;
      hsync_q     <= s3_hs_q;
      vsync_q     <= s3_vs_q;
      blank_n_q   <= s3_bright_q;
    end
  end

  // Lookup above sees the pre-write entry when write and read share an edge.
  always_ff @(posedge clk_50MHz) begin
    if (clear) begin
      for (int k = 0; k < 16; k++) pal_q[k] <= 8'h00;
    end else if (pal_we) begin
      pal_q[pal_idx] <= pal_data;
    end
  end

  assign tile_addr   = tile_addr_q;
  assign pat_addr    = pat_addr_q;
  assign rgb         = rgb_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_blank_n = blank_n_q;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Scoreboard bench for vga_tile_renderer: the driver queues the expected pin state and
// addresses for each pixel tick; the monitor pops and compares on every tick edge.
module tb_vga_tile_renderer;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        pix_en = 1'b0;
  logic [15:0] h_count = '0;
  logic [15:0] v_count = '0;
  logic        bright = 1'b0;
  logic        h_sync = 1'b1;
  logic        v_sync = 1'b1;
  logic [10:0] tile_addr;
  logic [7:0]  tile_data = 8'd5;
  logic [15:0] pat_addr;
  logic [3:0]  pat_data = 4'd0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_idx = '0;
  logic [7:0]  pal_data = '0;
  logic [7:0]  rgb;
  logic        vga_hsync, vga_vsync, vga_blank_n;

  always #10 clk = ~clk;

  vga_tile_renderer dut (
    .clk_50MHz  (clk),
    .clear      (clear),
    .pix_en     (pix_en),
    .h_count    (h_count),
    .v_count    (v_count),
    .bright     (bright),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .tile_addr  (tile_addr),
    .tile_data  (tile_data),
    .pat_addr   (pat_addr),
    .pat_data   (pat_data),
    .pal_we     (pal_we),
    .pal_idx    (pal_idx),
    .pal_data   (pal_data),
    .rgb        (rgb),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .vga_blank_n(vga_blank_n)
  );

  // Tile map holds 5 everywhere; pattern colour index = col ^ row ^ tile[3:0].
  logic [7:0] tile_mem [1200];
  initial for (int i = 0; i < 1200; i++) tile_mem[i] = 8'd5;
  always @(posedge clk) begin
    tile_data <= (tile_addr < 11'd1200) ? tile_mem[tile_addr] : 8'h00;
    pat_data  <= pat_addr[3:0] ^ pat_addr[7:4] ^ pat_addr[11:8];
  end

  typedef struct packed { logic [7:0] rgb; logic hs; logic vs; logic bl; } out_t;
  typedef struct packed { logic [10:0] ta; logic [15:0] pa; } adr_t;

  out_t exp_q[$];
  adr_t adr_q[$];
  logic [7:0]  pal_m [16];
  logic [10:0] ta_m;
  logic [3:0]  row_m, col_m;
  int n_vec = 0;
  int n_bad = 0;
  int n_tick = 0;

  out_t mon_e, mon_g;
  adr_t mon_ae, mon_ag;

  always begin
    @(posedge clk);
    if (pix_en && !clear) begin
      #1;
      n_tick++;
      n_vec++;
      mon_g = {rgb, vga_hsync, vga_vsync, vga_blank_n};
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pins tick %0d: got rgb=%h hs=%b vs=%b bl=%b, required entry missing",
                 n_tick, mon_g.rgb, mon_g.hs, mon_g.vs, mon_g.bl);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_g !== mon_e) begin
          n_bad++;
          $display("FAIL pins tick %0d: got rgb=%h hs=%b vs=%b bl=%b, required rgb=%h hs=%b vs=%b bl=%b",
                   n_tick, mon_g.rgb, mon_g.hs, mon_g.vs, mon_g.bl,
                   mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.bl);
        end else begin
          $display("tick %0d pins rgb=%h hs=%b vs=%b bl=%b ok", n_tick, mon_g.rgb, mon_g.hs,
                   mon_g.vs, mon_g.bl);
        end
      end
      n_vec++;
      mon_ag = {tile_addr, pat_addr};
      if (adr_q.size() == 0) begin
        n_bad++;
        $display("FAIL addr tick %0d: got tile=%0d pat=%h, required entry missing",
                 n_tick, mon_ag.ta, mon_ag.pa);
      end else begin
        mon_ae = adr_q.pop_front();
        if (mon_ag !== mon_ae) begin
          n_bad++;
          $display("FAIL addr tick %0d: got tile=%0d pat=%h, required tile=%0d pat=%h",
                   n_tick, mon_ag.ta, mon_ag.pa, mon_ae.ta, mon_ae.pa);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end else begin
      $display("%s: %h ok", name, got);
    end
  endtask

  task automatic tick(input int h, input int v, input bit br, input bit hs, input bit vs,
                      input bit pw = 1'b0, input logic [3:0] pi = 4'd0,
                      input logic [7:0] pd = 8'h00);
    logic [3:0] idx;
    out_t e;
    adr_t a;
    @(negedge clk);
    h_count  = 16'(h);
    v_count  = 16'(v);
    bright   = br;
    h_sync   = hs;
    v_sync   = vs;
    pix_en   = 1'b1;
    pal_we   = pw;
    pal_idx  = pi;
    pal_data = pd;
    if (pw) pal_m[pi] = pd;
    idx   = 4'(h) ^ 4'(v) ^ 4'd5;
    e.rgb = br ? pal_m[idx] : 8'h00;
    e.hs  = hs;
    e.vs  = vs;
    e.bl  = br;
    exp_q.push_back(e);
    a.pa  = {8'd5, row_m, col_m};
    row_m = 4'(v);
    col_m = 4'(h);
    if (br) ta_m = 11'((v / 16) * 40 + h / 16);
    a.ta  = ta_m;
    adr_q.push_back(a);
    @(negedge clk);
    pix_en = 1'b0;
    pal_we = 1'b0;
  endtask

  task automatic pal_write(input logic [3:0] i, input logic [7:0] d);
    @(negedge clk);
    pal_we   = 1'b1;
    pal_idx  = i;
    pal_data = d;
    @(negedge clk);
    pal_we   = 1'b0;
    pal_m[i] = d;
  endtask

  task automatic pal_init();
    for (int k = 0; k < 16; k++) pal_write(4'(k), (k == 3) ? 8'hE0 : 8'(k * 29 + 7));
  endtask

  task automatic flush(input int v);
    for (int k = 0; k < 3; k++) tick(640 + 2 * k, v, 1'b0, 1'b1, 1'b1);
  endtask

  // pix_en and pal_we are held high through clear to show they are ignored.
  task automatic do_clear(input int h);
    out_t r;
    @(negedge clk);
    clear    = 1'b1;
    h_count  = 16'(h);
    pix_en   = 1'b1;
    pal_we   = 1'b1;
    pal_idx  = 4'd3;
    pal_data = 8'hFF;
    @(posedge clk);
    #1;
    chk("reset_pins", 64'({rgb, vga_hsync, vga_vsync, vga_blank_n}), 64'({8'h00, 1'b1, 1'b1, 1'b0}));
    chk("reset_addr", 64'({tile_addr, pat_addr}), 64'd0);
    @(negedge clk);
    clear  = 1'b0;
    pix_en = 1'b0;
    pal_we = 1'b0;
    for (int k = 0; k < 16; k++) pal_m[k] = 8'h00;
    ta_m  = '0;
    row_m = '0;
    col_m = '0;
    exp_q.delete();
    adr_q.delete();
    r = {8'h00, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) exp_q.push_back(r);
  endtask

  logic [63:0] snap;

  initial begin
    do_clear(0);
    pal_init();

    // Reset in the middle of an active line; palette also returns to zero.
    for (int h = 288; h < 300; h += 2) tick(h, 100, 1'b1, (h != 296), 1'b1);
    do_clear(300);
    for (int h = 300; h <= 312; h += 2) tick(h, 100, 1'b1, 1'b1, 1'b1);
    flush(100);
    pal_init();

    // Address corners and sync variety.
    tick(639, 479, 1'b1, 1'b1, 1'b1);
    tick(16, 16, 1'b1, 1'b0, 1'b1);
    tick(33, 17, 1'b1, 1'b1, 1'b1);
    tick(0, 490, 1'b0, 1'b1, 1'b0);
    tick(2, 491, 1'b0, 1'b0, 1'b0);
    flush(491);

    // Bright rises on a palette[3] pixel while hsync leaves its pulse.
    tick(0, 32, 1'b0, 1'b0, 1'b1);
    tick(2, 32, 1'b0, 1'b0, 1'b1);
    tick(4, 32, 1'b0, 1'b1, 1'b1);
    tick(6, 32, 1'b1, 1'b1, 1'b1);
    tick(8, 32, 1'b1, 1'b1, 1'b1);
    tick(10, 32, 1'b1, 1'b1, 1'b1);
    flush(32);

    // Blanked pixels hit a bright palette entry yet must stay black.
    pal_write(4'd3, 8'hFF);
    tick(6, 32, 1'b0, 1'b1, 1'b1);
    tick(22, 32, 1'b0, 1'b1, 1'b1);
    tick(38, 48, 1'b0, 1'b1, 1'b1);
    pal_write(4'd3, 8'hE0);

    // Palette write on the same edge as an index-3 lookup.
    tick(22, 64, 1'b1, 1'b1, 1'b1);
    tick(24, 64, 1'b1, 1'b1, 1'b1);
    tick(26, 64, 1'b1, 1'b1, 1'b1);
    tick(6, 80, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 8'h1C);
    tick(8, 80, 1'b1, 1'b1, 1'b1);
    tick(10, 80, 1'b1, 1'b0, 1'b1);
    tick(12, 80, 1'b1, 1'b1, 1'b1);

    // Stall: inputs wander but nothing may move without pix_en.
    snap = 64'({rgb, vga_hsync, vga_vsync, vga_blank_n, tile_addr, pat_addr});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      h_count = 16'($urandom_range(0, 639));
      v_count = 16'($urandom_range(0, 479));
      bright  = 1'b1;
      h_sync  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("stall_hold", 64'({rgb, vga_hsync, vga_vsync, vga_blank_n, tile_addr, pat_addr}), snap);
    end
    tick(14, 80, 1'b1, 1'b1, 1'b1);
    tick(16, 80, 1'b1, 1'b1, 1'b1);
    tick(18, 80, 1'b1, 1'b1, 1'b0);
    flush(80);

    repeat (4) @(negedge clk);
    chk("pending_entries", 64'(exp_q.size()), 64'd3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
